// File: rtl/mul_div_unit.sv
// Multi-cycle signed 32x32 multiplier / 32/32 divider feeding RZ and ALUFinished.
// Radix-2 shift-add multiply and restoring divide on magnitudes, then one sign-fix cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [4:0]  OP_MUL = 5'b01111,
  parameter logic [4:0]  OP_DIV = 5'b10000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         ALUControl,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  output logic [2*WIDTH-1:0] result,
  output logic               finished,
  output logic               busy,
  output logic               divByZero
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e             state_q;
  logic [5:0]         cnt_q;
  logic [WIDTH:0]     a_q, b_q;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               sa_q, sb_q, div_q;

  logic               is_div, accept;
  logic [WIDTH:0]     abs_a, abs_b;
  logic [WIDTH+1:0]   mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod_mag, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic               b_zero;

  assign is_div = (ALUControl == OP_DIV);
  assign accept = start && (state_q == S_IDLE || state_q == S_DONE) &&
                  (ALUControl == OP_MUL || is_div);
  assign abs_a  = opA[WIDTH-1] ? -{opA[WIDTH-1], opA} : {1'b0, opA};
  assign abs_b  = opB[WIDTH-1] ? -{opB[WIDTH-1], opB} : {1'b0, opB};
  assign b_zero = (b_q == '0);

  // hi holds the running product high half (mul) or partial remainder (div);
  // lo holds the multiplier bits being shifted out (mul) or dividend/quotient bits (div).
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_trial = {1'b0, hi_q[WIDTH-1:0], lo_q[WIDTH-1]} - {1'b0, b_q};
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (div_q) begin
      hi_d = div_trial[WIDTH+1] ? {hi_q[WIDTH-1:0], lo_q[WIDTH-1]} : div_trial[WIDTH:0];
      lo_d = {lo_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
    end else begin
      hi_d = mul_sum[WIDTH+1:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_mag = {hi_q[WIDTH-1:0], lo_q};
    prod_s   = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
    quo_s    = b_zero ? '1 : ((sa_q ^ sb_q) ? -lo_q : lo_q);
    rem_s    = sa_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      div_q     <= 1'b0;
      result    <= '0;
      finished  <= 1'b0;
      busy      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q       <= abs_a;
            b_q       <= abs_b;
            sa_q      <= opA[WIDTH-1];
            sb_q      <= opB[WIDTH-1];
            div_q     <= is_div;
            hi_q      <= '0;
            lo_q      <= is_div ? abs_a[WIDTH-1:0] : abs_b[WIDTH-1:0];
            cnt_q     <= '0;
            finished  <= 1'b0;
            divByZero <= 1'b0;
            busy      <= 1'b1;
            state_q   <= is_div ? S_DIV : S_MUL;
          end
        end
        S_MUL, S_DIV: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == 6'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_FIX: begin
          result    <= div_q ? {rem_s, quo_s} : prod_s;
          divByZero <= div_q && b_zero;
          finished  <= 1'b1;
          busy      <= 1'b0;
          state_q   <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
